// File: rtl/cprs_4_2_dec.sv
// rtl/cprs_4_2_dec.sv - 4:2 compressor symbol decoder with FIFO and saturating ones accumulator
// Optional error counter enabled by defining CPRS_DEC_ERRCNT_EN.
module cprs_4_2_dec #(
    parameter int DEPTH = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_code,
    input  logic             in_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_word,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] acc,
    output logic [7:0]       err_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [3:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_base;
    logic [ACC_W:0]   acc_sum;
    logic [2:0]       pop_ones;
    logic [3:0]       dec_word;
    logic             push, pop;

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_word  = out_valid ? mem_q[rd_ptr_q] : 4'b0000;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign acc       = acc_q;

    always_comb begin
        dec_word = 4'b0000;
        if (in_err) begin
            dec_word = 4'b1111;
        end else begin
            case (in_code)
                2'd0:    dec_word = 4'b0000;
                2'd1:    dec_word = 4'b0001;
                2'd2:    dec_word = 4'b0011;
                default: dec_word = 4'b0111;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Clear is applied before the add so a coincident pop still counts.
    always_comb begin
        pop_ones = {2'b00, out_word[0]} + {2'b00, out_word[1]}
                 + {2'b00, out_word[2]} + {2'b00, out_word[3]};
        acc_base = acc_clr ? '0 : acc_q;
        acc_sum  = {1'b0, acc_base} + (pop ? (ACC_W+1)'(pop_ones) : '0);
        acc_d    = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            acc_q   <= acc_d;
        end
    end

    // Storage needs no reset: out_word is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec_word;
    end

`ifdef CPRS_DEC_ERRCNT_EN
    logic [7:0] err_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if (push && in_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_cprs_4_2_dec.sv
// tb/tb_cprs_4_2_dec.sv - self-checking bench for cprs_4_2_dec against a queue-based model
module tb_cprs_4_2_dec;
    localparam int DEPTH   = 4;
    localparam int ACC_MAX = 4095;
    localparam int SAT_MAX = 15;

    logic        clk, rst, in_valid, in_err, out_ready, acc_clr;
    logic [1:0]  in_code;
    logic        in_ready, out_valid, in_ready_s, out_valid_s;
    logic [3:0]  out_word, out_word_s;
    logic [11:0] acc;
    logic [3:0]  acc_s;
    logic [7:0]  err_cnt, err_cnt_s;

    int errors = 0;
    int checks = 0;

    logic [3:0] m_q[$];
    int         m_acc, m_acc_s, m_err;
    logic       popped;
    logic [3:0] exp_pop, obs_pop;

    cprs_4_2_dec #(.DEPTH(DEPTH), .ACC_W(12)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_err(in_err), .out_valid(out_valid),
        .out_ready(out_ready), .out_word(out_word), .acc_clr(acc_clr),
        .acc(acc), .err_cnt(err_cnt)
    );

    cprs_4_2_dec #(.DEPTH(DEPTH), .ACC_W(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_code(in_code), .in_err(in_err), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_word(out_word_s), .acc_clr(acc_clr),
        .acc(acc_s), .err_cnt(err_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] model_word(input logic e, input logic [1:0] c);
        int n;
        n = e ? 4 : int'(c);
        return 4'((1 << n) - 1);
    endfunction

    function automatic int sat_add(input int a, input int b, input int mx);
        return (a + b > mx) ? mx : a + b;
    endfunction

    // Drives one cycle, predicts push/pop from the model and advances the model.
    task automatic step(input logic r, input logic v, input logic [1:0] c,
                        input logic e, input logic ordy, input logic clr);
        logic do_push, do_pop;
        logic [3:0] w;
        rst = r; in_valid = v; in_code = c; in_err = e; out_ready = ordy; acc_clr = clr;
        @(negedge clk);
        do_push = v && (m_q.size() != DEPTH);
        do_pop  = ordy && (m_q.size() != 0);
        popped  = do_pop && !r;
        w       = model_word(e, c);
        if (do_pop) begin
            exp_pop = m_q[0];
            obs_pop = out_word;
        end
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_acc = 0; m_acc_s = 0; m_err = 0;
        end else begin
            if (clr) begin m_acc = 0; m_acc_s = 0; end
            if (do_pop) begin
                m_acc   = sat_add(m_acc, $countones(m_q[0]), ACC_MAX);
                m_acc_s = sat_add(m_acc_s, $countones(m_q[0]), SAT_MAX);
                void'(m_q.pop_front());
            end
            if (do_push) begin
                m_q.push_back(w);
`ifdef CPRS_DEC_ERRCNT_EN
                if (e) m_err = sat_add(m_err, 1, 255);
`endif
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_word !== 4'b0000) begin errors++; $display("FAIL reset_out_word got=%b exp=0000", out_word); end
        checks++; if (acc !== 12'd0) begin errors++; $display("FAIL reset_acc got=%0d exp=0", acc); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_decode();
        logic [3:0] tab [8];
        logic [2:0] s;
        int exp_err;
        tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            s = 3'(i);
            step(0, 1, s[1:0], s[2], 1, 0);
            checks++; if (out_valid !== 1'b1 || out_word !== tab[i])
                begin errors++; $display("FAIL decode_%0d got=%b/%b exp=1/%b", i, out_valid, out_word, tab[i]); end
        end
        step(0, 0, 0, 0, 1, 0);
        checks++; if (acc !== 12'd22) begin errors++; $display("FAIL decode_acc got=%0d exp=22", acc); end
`ifdef CPRS_DEC_ERRCNT_EN
        exp_err = 4;
`else
        exp_err = 0;
`endif
        checks++; if (int'(err_cnt) !== exp_err) begin errors++; $display("FAIL decode_err_cnt got=%0d exp=%0d", err_cnt, exp_err); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL decode_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_fill();
        logic [1:0] codes [4];
        logic [3:0] exp_w [4];
        logic       exp_rdy [4];
        codes = '{2'd1, 2'd2, 2'd3, 2'd1};
        exp_w = '{4'b0001, 4'b0011, 4'b0111, 4'b0001};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, codes[i], 0, 0, 0);
            checks++; if (in_ready !== exp_rdy[i]) begin errors++; $display("FAIL fill_in_ready_%0d got=%b exp=%b", i, in_ready, exp_rdy[i]); end
        end
        step(0, 1, 2'd3, 1, 0, 0);
        checks++; if (in_ready !== 1'b0 || out_word !== 4'b0001)
            begin errors++; $display("FAIL fill_fifth got=%b/%b exp=0/0001", in_ready, out_word); end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 0);
            checks++; if (!popped || obs_pop !== exp_w[i])
                begin errors++; $display("FAIL fill_pop_%0d got=%b exp=%b", i, obs_pop, exp_w[i]); end
            if (i == 0) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_return got=%b exp=1", in_ready); end
            end
        end
        checks++; if (out_valid !== 1'b0 || acc !== 12'(m_acc))
            begin errors++; $display("FAIL fill_end got=%b/%0d exp=0/%0d", out_valid, acc, m_acc); end
    endtask

    task automatic test_back_to_back();
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 2'd1, 0, 0, 0);
        step(0, 1, 2'd2, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1, 0);
            checks++; if (!popped || obs_pop !== exp_pop || out_valid !== 1'b1 || in_ready !== 1'b1 || m_q.size() != 2)
                begin errors++; $display("FAIL b2b_%0d got=%b exp=%b v=%b r=%b", i, obs_pop, exp_pop, out_valid, in_ready); end
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 1, 0);
            checks++; if (obs_pop !== exp_pop) begin errors++; $display("FAIL b2b_drain_%0d got=%b exp=%b", i, obs_pop, exp_pop); end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_acc_clr();
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 2'd0, 1, 0, 0);
        step(0, 1, 2'd0, 1, 0, 0);
        step(0, 1, 2'd1, 0, 0, 0);
        step(0, 1, 2'd3, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
        checks++; if (acc !== 12'd9) begin errors++; $display("FAIL clr_pre got=%0d exp=9", acc); end
        step(0, 0, 0, 0, 1, 1);
        checks++; if (acc !== 12'd3) begin errors++; $display("FAIL clr_with_pop got=%0d exp=3", acc); end
        step(0, 0, 0, 0, 1, 1);
        checks++; if (acc !== 12'd0) begin errors++; $display("FAIL clr_alone got=%0d exp=0", acc); end
    endtask

    task automatic test_saturation();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 2'($urandom_range(0, 3)), 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        checks++; if (acc_s !== 4'd15) begin errors++; $display("FAIL sat_acc4 got=%0d exp=15", acc_s); end
        checks++; if (acc !== 12'd20) begin errors++; $display("FAIL sat_acc12 got=%0d exp=20", acc); end
        for (int i = 0; i < 300; i++) step(0, 1, 2'($urandom_range(0, 3)), 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        checks++; if (int'(err_cnt) !== m_err) begin errors++; $display("FAIL sat_err_cnt got=%0d exp=%0d", err_cnt, m_err); end
        checks++; if (acc_s !== 4'd15 || int'(acc) !== m_acc) begin errors++; $display("FAIL sat_hold got=%0d/%0d exp=15/%0d", acc_s, acc, m_acc); end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 2'd3, i == 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(1, 1, 2'd2, 0, 0, 0);
        checks++; if (out_valid !== 1'b0 || out_word !== 4'b0000 || in_ready !== 1'b1 || acc !== 12'd0 || err_cnt !== 8'd0)
            begin errors++; $display("FAIL rst_mid got v=%b w=%b r=%b acc=%0d ec=%0d exp 0/0000/1/0/0", out_valid, out_word, in_ready, acc, err_cnt); end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 0);
            checks++; if (out_valid !== 1'b0 || out_word !== 4'b0000)
                begin errors++; $display("FAIL rst_stale_%0d got=%b/%b exp=0/0000", i, out_valid, out_word); end
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_w;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0), ($urandom_range(0, 29) == 0));
            exp_w = (m_q.size() != 0) ? m_q[0] : 4'b0000;
            checks++; if (in_ready !== (m_q.size() != DEPTH) || out_valid !== (m_q.size() != 0) || out_word !== exp_w || out_word_s !== exp_w)
                begin errors++; $display("FAIL rand_fifo_%0d got r=%b v=%b w=%b exp w=%b n=%0d", i, in_ready, out_valid, out_word, exp_w, m_q.size()); end
            checks++; if (int'(acc) !== m_acc || int'(acc_s) !== m_acc_s || int'(err_cnt) !== m_err)
                begin errors++; $display("FAIL rand_cnt_%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, acc, acc_s, err_cnt, m_acc, m_acc_s, m_err); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = 2'd0; in_err = 1'b0; out_ready = 1'b0; acc_clr = 1'b0;
        m_acc = 0; m_acc_s = 0; m_err = 0; popped = 1'b0; exp_pop = '0; obs_pop = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_decode();
        test_fill();
        test_back_to_back();
        test_acc_clr();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
